// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared widths, FSM states and error codes for the split-access responder
package mem_if_pkg;
   localparam int HALF_W = 16;
   localparam int WORD_W = 32;
   typedef enum logic {ST_LOW, ST_HIGH} resp_state_e;
   typedef enum logic [1:0] {ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_PAIR} err_e;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: split 32-bit access bus between the execute/mem initiator and the memory responder
interface data_mem_responder_if;
   import mem_if_pkg::*;
   logic              mem_re_i;
   logic              mem_we_i;
   logic [WORD_W-1:0] data_mem_addr_i;
   logic [HALF_W-1:0] data_mem_i;
   logic [HALF_W-1:0] data_mem_o;
   logic [WORD_W-1:0] rd_word_o;
   logic              rd_word_valid_o;
   logic              wr_done_o;
   logic              err_o;
   err_e              err_code_o;
   modport master (
      output mem_re_i, mem_we_i, data_mem_addr_i, data_mem_i,
      input  data_mem_o, rd_word_o, rd_word_valid_o, wr_done_o, err_o, err_code_o
   );
   modport slave (
      input  mem_re_i, mem_we_i, data_mem_addr_i, data_mem_i,
      output data_mem_o, rd_word_o, rd_word_valid_o, wr_done_o, err_o, err_code_o
   );
endinterface

// File: rtl/data_mem_responder_hw_ram.sv
// hw_ram: single-port synchronous halfword RAM, one-cycle read returning pre-write contents
module hw_ram
   import mem_if_pkg::*;
#(
   parameter int DEPTH_HW = 1024,
   parameter int IDX_W    = $clog2(DEPTH_HW)
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [HALF_W-1:0] wdata,
   output logic [HALF_W-1:0] q
);
   logic [HALF_W-1:0] mem [DEPTH_HW];
   // Read returns the old contents when the same index is written in the same cycle
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[idx] <= wdata;
         q <= mem[idx];
      end
   end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: pairs low/high halfword accesses, stores them in RAM, rebuilds read words, latches errors
module data_mem_responder
   import mem_if_pkg::*;
#(
   parameter int          DEPTH_HW  = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input logic           clk_i,
   input logic           rst_i,
   data_mem_responder_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH_HW);
   resp_state_e       state;
   logic [WORD_W-1:0] addr_q;
   logic              op_re_q;
   logic [HALF_W-1:0] low_q;
   logic [HALF_W-1:0] ram_q;
   logic              rd_q;
   logic [WORD_W-1:0] off;
   logic              req;
   logic              in_range;
   logic              match;
   logic              go;
   err_e              code;
   // Classify the current half: legal low/high half or the error it raises
   always_comb begin
      off      = bus.data_mem_addr_i - BASE_ADDR;
      req      = bus.mem_re_i ^ bus.mem_we_i;
      in_range = (off >> 1) < 32'(DEPTH_HW);
      match    = req && (bus.mem_re_i == op_re_q) && (bus.data_mem_addr_i == addr_q + 32'd2);
      code     = (state == ST_HIGH) ? (!match ? ERR_PAIR : !in_range ? ERR_RANGE : ERR_NONE)
               : (bus.mem_re_i && bus.mem_we_i) ? ERR_PAIR
               : !req ? ERR_NONE
               : bus.data_mem_addr_i[0] ? ERR_MISALIGN
               : !in_range ? ERR_RANGE : ERR_NONE;
      go       = req && (code == ERR_NONE);
   end
   hw_ram #(.DEPTH_HW(DEPTH_HW)) u_ram (
      .clk   (clk_i),
      .en    (go),
      .we    (go && bus.mem_we_i && !rst_i),
      .idx   (off[IDX_W:1]),
      .wdata (bus.data_mem_i),
      .q     (ram_q)
   );
   assign bus.data_mem_o = rd_q ? ram_q : '0;
   assign bus.rd_word_o  = bus.rd_word_valid_o ? {bus.data_mem_o, low_q} : '0;
   // Pairing FSM with registered completion pulses, low-half capture and sticky first-error latch
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state               <= ST_LOW;
         addr_q              <= '0;
         op_re_q             <= 1'b0;
         low_q               <= '0;
         rd_q                <= 1'b0;
         bus.rd_word_valid_o <= 1'b0;
         bus.wr_done_o       <= 1'b0;
         bus.err_o           <= 1'b0;
         bus.err_code_o      <= ERR_NONE;
      end else begin
         rd_q                <= go && bus.mem_re_i;
         bus.rd_word_valid_o <= go && bus.mem_re_i && (state == ST_HIGH);
         bus.wr_done_o       <= go && bus.mem_we_i && (state == ST_HIGH);
         if (state == ST_HIGH) low_q <= bus.data_mem_o;
         if (code != ERR_NONE && !bus.err_o) bus.err_code_o <= code;
         if (code != ERR_NONE) bus.err_o <= 1'b1;
         if (state == ST_LOW && go) begin
            state   <= ST_HIGH;
            addr_q  <= bus.data_mem_addr_i;
            op_re_q <= bus.mem_re_i;
         end else begin
            state <= ST_LOW;
         end
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed pair/error/reset scenarios checked every cycle against a transaction-level model
module tb_data_mem_responder;
   import mem_if_pkg::*;
   localparam int DEPTH = 1024;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   bit   chk_en = 1'b0;
   data_mem_responder_if bus();
   data_mem_responder #(.DEPTH_HW(DEPTH), .BASE_ADDR(32'h0)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   always #5 clk = ~clk;

   logic [15:0] m_mem [DEPTH];
   bit          pend = 1'b0;
   logic [31:0] pend_a = '0;
   bit          pend_re = 1'b0;
   logic [15:0] pend_low = '0;
   logic [15:0] exp_data = '0;
   logic [31:0] exp_word = '0;
   bit          exp_valid = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
   logic [1:0]  exp_code = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: each edge consumes one half and decides what the next cycle must show
   always @(posedge clk) begin
      automatic logic        re = bus.mem_re_i, we = bus.mem_we_i;
      automatic logic [31:0] a = bus.data_mem_addr_i;
      automatic bit          inr = a < 32'(2 * DEPTH);
      automatic int          idx = inr ? int'(a >> 1) : 0;
      automatic int          e = 0;
      exp_data = '0; exp_word = '0; exp_valid = 0; exp_done = 0;
      if (rst) begin
         pend = 0; exp_err = 0; exp_code = 0;
      end else begin
         if (pend) e = ((re ^ we) && re == pend_re && a == pend_a + 32'd2) ? (inr ? 0 : 2) : 3;
         else e = (re && we) ? 3 : !(re || we) ? 0 : a[0] ? 1 : !inr ? 2 : 0;
         if (e != 0) begin
            if (!exp_err) exp_code = 2'(e);
            exp_err = 1; pend = 0;
         end else if (re || we) begin
            if (re) exp_data = m_mem[idx];
            if (pend) begin
               exp_valid = re; exp_done = we;
               if (re) exp_word = {m_mem[idx], pend_low};
               pend = 0;
            end else begin
               pend = 1; pend_a = a; pend_re = re; pend_low = m_mem[idx];
            end
            if (we) m_mem[idx] = bus.data_mem_i;
         end
      end
   end

   // Every cycle after the first reset edge all outputs must match the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("data_mem_o", 32'(bus.data_mem_o), 32'(exp_data));
         chk("rd_word_o", bus.rd_word_o, exp_word);
         chk("rd_word_valid_o", 32'(bus.rd_word_valid_o), 32'(exp_valid));
         chk("wr_done_o", 32'(bus.wr_done_o), 32'(exp_done));
         chk("err_o", 32'(bus.err_o), 32'(exp_err));
         chk("err_code_o", 32'(bus.err_code_o), 32'(exp_code));
      end
   end

   task automatic cyc(input logic r, input logic re, input logic we, input logic [31:0] a, input logic [15:0] d);
      @(posedge clk);
      #1;
      rst = r; bus.mem_re_i = re; bus.mem_we_i = we; bus.data_mem_addr_i = a; bus.data_mem_i = d;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 32'h0, 16'h0);
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 32'h0, 16'h0);
      idle();
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      bus.mem_re_i = 0; bus.mem_we_i = 0; bus.data_mem_addr_i = '0; bus.data_mem_i = '0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      idle();
      @(negedge clk);
      chk("reset err_o", 32'(bus.err_o), 32'h0);
      chk("reset data_mem_o", 32'(bus.data_mem_o), 32'h0);
      // write pair
      cyc(0, 0, 1, 32'h10, 16'hBEEF);
      cyc(0, 0, 1, 32'h12, 16'hDEAD);
      idle();
      @(negedge clk);
      chk("t1 wr_done", 32'(bus.wr_done_o), 32'h1);
      chk("t1 model ram8", 32'(m_mem[8]), 32'hBEEF);
      chk("t1 model ram9", 32'(m_mem[9]), 32'hDEAD);
      // read it back
      cyc(0, 1, 0, 32'h10, 16'h0);
      cyc(0, 1, 0, 32'h12, 16'h0);
      @(negedge clk);
      chk("t2 low half", 32'(bus.data_mem_o), 32'hBEEF);
      idle();
      @(negedge clk);
      chk("t2 high half", 32'(bus.data_mem_o), 32'hDEAD);
      chk("t2 word", bus.rd_word_o, 32'hDEADBEEF);
      chk("t2 valid", 32'(bus.rd_word_valid_o), 32'h1);
      // preload 0x20 for the pair-break follow-up
      cyc(0, 0, 1, 32'h20, 16'h1234);
      cyc(0, 0, 1, 32'h22, 16'h5678);
      idle();
      // misaligned, then a range error must not replace the code
      cyc(0, 0, 1, 32'h11, 16'hAAAA);
      idle();
      @(negedge clk);
      chk("t3 err_o", 32'(bus.err_o), 32'h1);
      chk("t3 code", 32'(bus.err_code_o), 32'(ERR_MISALIGN));
      cyc(0, 0, 1, 32'h800, 16'h5555);
      idle();
      idle();
      @(negedge clk);
      chk("t3 code kept", 32'(bus.err_code_o), 32'(ERR_MISALIGN));
      // pair break, then a legal pair
      do_reset();
      cyc(0, 1, 0, 32'h20, 16'h0);
      idle();
      idle();
      @(negedge clk);
      chk("t4 no valid", 32'(bus.rd_word_valid_o), 32'h0);
      chk("t4 code", 32'(bus.err_code_o), 32'(ERR_PAIR));
      cyc(0, 1, 0, 32'h20, 16'h0);
      cyc(0, 1, 0, 32'h22, 16'h0);
      idle();
      @(negedge clk);
      chk("t4 follow word", bus.rd_word_o, 32'h56781234);
      // re and we together
      do_reset();
      cyc(0, 1, 1, 32'h10, 16'h0);
      idle();
      @(negedge clk);
      chk("re&we code", 32'(bus.err_code_o), 32'(ERR_PAIR));
      // range: last two legal halves, then a pair straddling the top, then fully outside
      do_reset();
      cyc(0, 0, 1, 32'h7FC, 16'h1111);
      cyc(0, 0, 1, 32'h7FE, 16'h2222);
      idle();
      @(negedge clk);
      chk("top pair done", 32'(bus.wr_done_o), 32'h1);
      cyc(0, 0, 1, 32'h800, 16'h3333);
      cyc(0, 0, 1, 32'h802, 16'h4444);
      idle();
      @(negedge clk);
      chk("t5 no done", 32'(bus.wr_done_o), 32'h0);
      chk("t5 code", 32'(bus.err_code_o), 32'(ERR_RANGE));
      do_reset();
      cyc(0, 0, 1, 32'h7FE, 16'h6666);
      cyc(0, 0, 1, 32'h800, 16'h7777);
      idle();
      @(negedge clk);
      chk("straddle code", 32'(bus.err_code_o), 32'(ERR_RANGE));
      // reset mid-pair
      do_reset();
      cyc(0, 1, 0, 32'h10, 16'h0);
      cyc(1, 1, 0, 32'h12, 16'h0);
      @(negedge clk);
      chk("t6 low before rst", 32'(bus.data_mem_o), 32'hBEEF);
      idle();
      @(negedge clk);
      chk("t6 no valid", 32'(bus.rd_word_valid_o), 32'h0);
      chk("t6 data zero", 32'(bus.data_mem_o), 32'h0);
      cyc(0, 1, 0, 32'h10, 16'h0);
      cyc(0, 1, 0, 32'h12, 16'h0);
      idle();
      @(negedge clk);
      chk("t6 ram kept", bus.rd_word_o, 32'hDEADBEEF);
      idle();
      idle();
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
